// File: rtl/ebi_req_arbiter.sv
// Two-port round-robin arbiter sharing one EBI master AR/AW/W/R port.
// Ports: clk/rst, m_* per-requester L2 side (x2), s_* EBI side, rd/wr busy.
module ebi_req_arbiter #(
  parameter int DATA_WIDTH       = 64,
  parameter int PADDR_WIDTH      = 32,
  parameter int CACHELINE_LENGTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               m_arvalid_i,
  output logic [1:0]               m_arready_o,
  input  logic [2*PADDR_WIDTH-1:0] m_araddr_i,
  input  logic [3:0]               m_arid_i,
  input  logic [7:0]               m_arsnoop_i,
  input  logic [1:0]               m_awvalid_i,
  output logic [1:0]               m_awready_o,
  input  logic [2*PADDR_WIDTH-1:0] m_awaddr_i,
  input  logic [3:0]               m_awmesi_i,
  input  logic [1:0]               m_wvalid_i,
  output logic [1:0]               m_wready_o,
  input  logic [2*DATA_WIDTH-1:0]  m_wdata_i,
  output logic [1:0]               m_rvalid_o,
  input  logic [1:0]               m_rready_i,
  output logic [1:0]               m_rid_o,
  output logic [DATA_WIDTH-1:0]    m_rdata_o,
  output logic [1:0]               m_mesi_o,
  output logic                     s_arvalid_o,
  output logic [PADDR_WIDTH-1:0]   s_araddr_o,
  output logic [1:0]               s_arid_o,
  output logic [3:0]               s_arsnoop_o,
  input  logic                     s_arready_i,
  output logic                     s_awvalid_o,
  output logic [PADDR_WIDTH-1:0]   s_awaddr_o,
  output logic [1:0]               s_awmesi_o,
  input  logic                     s_awready_i,
  output logic                     s_wvalid_o,
  output logic [DATA_WIDTH-1:0]    s_wdata_o,
  input  logic                     s_wready_i,
  input  logic                     s_rvalid_i,
  input  logic [1:0]               s_rid_i,
  input  logic [DATA_WIDTH-1:0]    s_rdata_i,
  input  logic [1:0]               s_mesi_i,
  output logic                     s_rready_o,
  output logic                     rd_busy_o,
  output logic                     wr_busy_o
);

  localparam int BEATS = CACHELINE_LENGTH / DATA_WIDTH;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    RD_IDLE, RD_REQ, RD_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE, WR_REQ, WR_DATA
  } wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic rd_owner, rd_owner_n;
  logic rd_ptr, rd_ptr_n;
  logic wr_owner, wr_owner_n;
  logic wr_ptr, wr_ptr_n;
  logic [CW-1:0] rd_cnt, rd_cnt_n;
  logic [CW-1:0] wr_cnt, wr_cnt_n;

  // Sole requester wins outright; a tie goes to the pointer.
  function automatic logic pick(
    input logic [1:0] v,
    input logic       p
  );
    return (&v) ? p : v[1];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
      rd_owner <= 1'b0;
      wr_owner <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      rd_owner <= rd_owner_n;
      wr_owner <= wr_owner_n;
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
      rd_cnt   <= rd_cnt_n;
      wr_cnt   <= wr_cnt_n;
    end
  end

  always_comb begin
    rd_next     = rd_state;
    rd_owner_n  = rd_owner;
    rd_ptr_n    = rd_ptr;
    rd_cnt_n    = rd_cnt;
    s_arvalid_o = 1'b0;
    s_araddr_o  = '0;
    s_arid_o    = '0;
    s_arsnoop_o = '0;
    m_arready_o = '0;
    m_rvalid_o  = '0;
    s_rready_o  = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        if (|m_arvalid_i) begin
          rd_owner_n = pick(m_arvalid_i, rd_ptr);
          rd_ptr_n   = ~rd_owner_n;
          rd_next    = RD_REQ;
        end
      end
      RD_REQ: begin
        s_arvalid_o = 1'b1;
        s_araddr_o  = rd_owner ? m_araddr_i[2*PADDR_WIDTH-1:PADDR_WIDTH]
                               : m_araddr_i[PADDR_WIDTH-1:0];
        s_arid_o    = rd_owner ? m_arid_i[3:2] : m_arid_i[1:0];
        s_arsnoop_o = rd_owner ? m_arsnoop_i[7:4] : m_arsnoop_i[3:0];
        m_arready_o[rd_owner] = s_arready_i;
        if (s_arready_i) rd_next = RD_DATA;
      end
      RD_DATA: begin
        m_rvalid_o[rd_owner] = s_rvalid_i;
        s_rready_o = m_rready_i[rd_owner];
        if (s_rvalid_i && m_rready_i[rd_owner]) begin
          if (rd_cnt == LAST) begin
            rd_cnt_n = '0;
            rd_next  = RD_IDLE;
          end else begin
            rd_cnt_n = rd_cnt + CW'(1);
          end
        end
      end
      default: rd_next = RD_IDLE;
    endcase
    if (rst) begin
      s_arvalid_o = 1'b0;
      s_araddr_o  = '0;
      s_arid_o    = '0;
      s_arsnoop_o = '0;
      m_arready_o = '0;
      m_rvalid_o  = '0;
      s_rready_o  = 1'b0;
    end
  end

  always_comb begin
    wr_next     = wr_state;
    wr_owner_n  = wr_owner;
    wr_ptr_n    = wr_ptr;
    wr_cnt_n    = wr_cnt;
    s_awvalid_o = 1'b0;
    s_awaddr_o  = '0;
    s_awmesi_o  = '0;
    m_awready_o = '0;
    s_wvalid_o  = 1'b0;
    s_wdata_o   = '0;
    m_wready_o  = '0;
    unique case (wr_state)
      WR_IDLE: begin
        if (|m_awvalid_i) begin
          wr_owner_n = pick(m_awvalid_i, wr_ptr);
          wr_ptr_n   = ~wr_owner_n;
          wr_next    = WR_REQ;
        end
      end
      WR_REQ: begin
        s_awvalid_o = 1'b1;
        s_awaddr_o  = wr_owner ? m_awaddr_i[2*PADDR_WIDTH-1:PADDR_WIDTH]
                               : m_awaddr_i[PADDR_WIDTH-1:0];
        s_awmesi_o  = wr_owner ? m_awmesi_i[3:2] : m_awmesi_i[1:0];
        m_awready_o[wr_owner] = s_awready_i;
        // Only a Modified line carries a data phase.
        if (s_awready_i) begin
          wr_next = (s_awmesi_o == 2'b11) ? WR_DATA : WR_IDLE;
        end
      end
      WR_DATA: begin
        s_wvalid_o = m_wvalid_i[wr_owner];
        s_wdata_o  = wr_owner ? m_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                              : m_wdata_i[DATA_WIDTH-1:0];
        m_wready_o[wr_owner] = s_wready_i;
        if (s_wready_i && m_wvalid_i[wr_owner]) begin
          if (wr_cnt == LAST) begin
            wr_cnt_n = '0;
            wr_next  = WR_IDLE;
          end else begin
            wr_cnt_n = wr_cnt + CW'(1);
          end
        end
      end
      default: wr_next = WR_IDLE;
    endcase
    if (rst) begin
      s_awvalid_o = 1'b0;
      s_awaddr_o  = '0;
      s_awmesi_o  = '0;
      m_awready_o = '0;
      s_wvalid_o  = 1'b0;
      s_wdata_o   = '0;
      m_wready_o  = '0;
    end
  end

  always_comb begin
    m_rid_o   = rst ? 2'b00 : s_rid_i;
    m_rdata_o = rst ? '0 : s_rdata_i;
    m_mesi_o  = rst ? 2'b00 : s_mesi_i;
    rd_busy_o = !rst && (rd_state != RD_IDLE);
    wr_busy_o = !rst && (wr_state != WR_IDLE);
  end

endmodule

// File: doc/ebi_req_arbiter.md
# ebi_req_arbiter

Two-port request arbiter in front of the on-chip EBI master's cache-side request interface. It shares the single AR/AW/W/R port of the EBI master between two L2-side requesters (index 0 and 1). Read and write paths use independent round-robin arbitration. Each granted requester is locked to its path until the full cacheline transfer on that path has completed.

## Interface
Parameters:
- DATA_WIDTH, 64, beat width of W and R data
- PADDR_WIDTH, 32, physical address width
- CACHELINE_LENGTH, 512, bits per line; BEATS = CACHELINE_LENGTH/DATA_WIDTH (8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m_arvalid_i  in  2  per-requester AR valid; bit i = requester i
- m_arready_o  out  2  per-requester AR ready
- m_araddr_i  in  2*PADDR_WIDTH  AR address; slice i = requester i
- m_arid_i  in  4  AR id, 2 bits per requester
- m_arsnoop_i  in  8  AR snoop code, 4 bits per requester
- m_awvalid_i / m_awready_o  in/out  2 each  per-requester AW handshake
- m_awaddr_i  in  2*PADDR_WIDTH  AW address
- m_awmesi_i  in  4  AW MESI state, 2 bits per requester; 2'b11 = M (carries data)
- m_wvalid_i / m_wready_o  in/out  2 each  per-requester W handshake
- m_wdata_i  in  2*DATA_WIDTH  W data
- m_rvalid_o  out  2  per-requester R valid
- m_rready_i  in  2  per-requester R ready
- m_rid_o  out  2  R id, broadcast to both requesters
- m_rdata_o  out  DATA_WIDTH  R data, broadcast to both requesters
- m_mesi_o  out  2  R MESI state, broadcast to both requesters
- s_arvalid_o, s_araddr_o, s_arid_o, s_arsnoop_o  out  1/PADDR_WIDTH/2/4  AR channel to EBI
- s_arready_i  in  1  EBI AR ready
- s_awvalid_o, s_awaddr_o, s_awmesi_o  out  1/PADDR_WIDTH/2  AW channel to EBI
- s_awready_i  in  1  EBI AW ready
- s_wvalid_o, s_wdata_o  out  1/DATA_WIDTH  W channel to EBI
- s_wready_i  in  1  EBI W ready
- s_rvalid_i, s_rid_i, s_rdata_i, s_mesi_i  in  1/2/DATA_WIDTH/2  R channel from EBI
- s_rready_o  out  1  R ready to EBI
- rd_busy_o, wr_busy_o  out  1 each  read/write path not in IDLE

## Operation
Read FSM, states RD_IDLE, RD_REQ, RD_DATA:
- RD_IDLE: if any m_arvalid_i bit is set, latch the winner into rd_owner and go to RD_REQ. With both bits set, the winner is rd_ptr. rd_ptr then becomes ~winner.
- RD_REQ: s_arvalid_o=1 and the AR fields are muxed from rd_owner. m_arready_o[rd_owner]=s_arready_i. On the handshake, go to RD_DATA.
- RD_DATA: m_rvalid_o[rd_owner]=s_rvalid_i and s_rready_o=m_rready_i[rd_owner]. The non-owner's rvalid is 0. A 3-bit beat counter increments on each R handshake. The handshake at count BEATS-1 returns the FSM to RD_IDLE and clears the counter.

Write FSM, states WR_IDLE, WR_REQ, WR_DATA:
- WR_IDLE: arbitration is the same as the read FSM, using wr_ptr and wr_owner. Go to WR_REQ.
- WR_REQ: the AW fields are muxed from wr_owner. On the AW handshake, go to WR_DATA if s_awmesi_o==2'b11, otherwise go to WR_IDLE.
- WR_DATA: s_wvalid_o=m_wvalid_i[wr_owner] and m_wready_o[wr_owner]=s_wready_i. A 3-bit counter increments on each W handshake. The handshake at count BEATS-1 returns the FSM to WR_IDLE.

Common rules:
- The read and write paths are independent and may be active simultaneously.
- The arbiter enforces no ordering between them.
- The non-owner requester sees ready=0 on all channels of the owned path.
- Requesters must hold valid and payload until the handshake. The arbiter does not re-arbitrate a path while it is in REQ.
- A read response arriving in RD_IDLE or RD_REQ is held off with s_rready_o=0.

## Timing
- Reset: all FSMs go to IDLE, rd_ptr=wr_ptr=0, counters=0.
- Outputs during reset: all *_valid_o, *_ready_o and busy outputs are 0. Data outputs are 0.
- Arbitration latency: m_arvalid_i/m_awvalid_i high in cycle N gives s_*valid_o high in cycle N+1 at the earliest.
- After a completing handshake, the path re-arbitrates in the next cycle. The back-to-back gap is one IDLE cycle.
- A requester's valid pulse that is dropped before a grant is lost. This is a protocol violation and is not guarded.
- rst mid-transfer aborts the transfer immediately. No partial-beat recovery is performed.
- Beat counters are 3 bits wide and wrap only by transitioning out of DATA.

## Test plan
- Single read from requester 1, addr 0x8000_0040, arid 2 → s_araddr_o=0x8000_0040 one cycle after valid. 8 R beats reach only m_rvalid_o[1]. rd_busy_o falls after beat 7.
- Both requesters assert AR in the same cycle after reset → requester 0 is granted first and requester 1 second. rd_ptr alternates 0→1→0.
- AW with mesi 2'b11 from requester 0 → the W path is locked to requester 0 for 8 beats. Requester 1's m_wready_o stays 0 throughout. Data order is preserved.
- AW with mesi 2'b01 → the write path returns to WR_IDLE after the AW handshake. No W beats are forwarded.
- Concurrent read owned by 1 and write owned by 0 → both complete. No cross-routing: rvalid only on port 1, wready only on port 0.
- rst asserted at R beat 4 → the next cycle has both FSMs idle, all valids 0 and ptrs 0.
